// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus decoder: FSM states, the latched
// request record and the default target-1 address window.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusyT0,
    StBusyT1,
    StResp
  } state_t;

  typedef struct packed {
    logic [19:1] addr;
    logic [15:0] data;
    logic        wr_en;
    logic [1:0]  bytesel;
  } req_t;

  localparam logic [19:1] DefWinBase       = 19'h7C000;
  localparam logic [19:1] DefWinMask       = 19'h7C000;
  localparam int unsigned DefTimeoutCycles = 255;

  localparam logic [15:0] AbortData = 16'hFFFF;

  function automatic logic win_hit(input logic [19:1] addr,
                                   input logic [19:1] base,
                                   input logic [19:1] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Busy-cycle watchdog for the memory bus decoder. Flags expiry in the busy cycle whose
// count would reach Limit, so the abort lands after exactly Limit unacknowledged cycles.
module mem_bus_timeout #(
  parameter int unsigned Limit = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [7:0] LimitM1 = 8'(Limit - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LimitM1)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LimitM1);

endmodule

// File: rtl/mem_bus_decoder.sv
// Single-master, two-target bus responder: window hit goes to target 1, all else to target 0.
// Optional busy timeout abort is compiled in with MEM_BUS_DECODER_TIMEOUT_EN.
module mem_bus_decoder
  import mem_bus_pkg::*;
#(
  parameter logic [19:1] WIN_BASE       = DefWinBase,
  parameter logic [19:1] WIN_MASK       = DefWinMask,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic        clk,
  input  logic        reset,
  // Master side
  input  logic [19:1] h_m_addr,
  output logic [15:0] h_m_data_in,
  input  logic [15:0] h_m_data_out,
  input  logic        h_m_access,
  output logic        h_m_ack,
  input  logic        h_m_wr_en,
  input  logic [1:0]  h_m_bytesel,
  // Target 0
  output logic [19:1] t0_m_addr,
  input  logic [15:0] t0_m_data_in,
  output logic [15:0] t0_m_data_out,
  output logic        t0_m_access,
  input  logic        t0_m_ack,
  output logic        t0_m_wr_en,
  output logic [1:0]  t0_m_bytesel,
  // Target 1
  output logic [19:1] t1_m_addr,
  input  logic [15:0] t1_m_data_in,
  output logic [15:0] t1_m_data_out,
  output logic        t1_m_access,
  input  logic        t1_m_ack,
  output logic        t1_m_wr_en,
  output logic [1:0]  t1_m_bytesel,
  output logic        bus_error
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range_check
    $error("mem_bus_decoder: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic [15:0] rsp_q, rsp_d;
  logic        err_q, err_d;

  logic        busy;
  logic        sel_ack;
  logic [15:0] sel_rdata;
  logic        expired;

  assign busy      = (state_q == StBusyT0) || (state_q == StBusyT1);
  assign sel_ack   = (state_q == StBusyT1) ? t1_m_ack : t0_m_ack;
  assign sel_rdata = (state_q == StBusyT1) ? t1_m_data_in : t0_m_data_in;

`ifdef MEM_BUS_DECODER_TIMEOUT_EN
  mem_bus_timeout #(
    .Limit(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (reset),
    .clr_i    (state_q == StIdle),
    .en_i     (busy && !sel_ack),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (h_m_access) begin
          req_d = '{addr: h_m_addr, data: h_m_data_out, wr_en: h_m_wr_en,
                    bytesel: h_m_bytesel};
          state_d = win_hit(h_m_addr, WIN_BASE, WIN_MASK) ? StBusyT1 : StBusyT0;
        end
      end
      StBusyT0, StBusyT1: begin
        // A target ack in the expiry cycle takes priority over the abort.
        if (sel_ack) begin
          rsp_d   = sel_rdata;
          state_d = StResp;
        end else if (expired) begin
          rsp_d   = AbortData;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

  // Both targets see the request register; only access selects who responds.
  assign t0_m_addr     = req_q.addr;
  assign t0_m_data_out = req_q.data;
  assign t0_m_wr_en    = req_q.wr_en;
  assign t0_m_bytesel  = req_q.bytesel;
  assign t0_m_access   = (state_q == StBusyT0);

  assign t1_m_addr     = req_q.addr;
  assign t1_m_data_out = req_q.data;
  assign t1_m_wr_en    = req_q.wr_en;
  assign t1_m_bytesel  = req_q.bytesel;
  assign t1_m_access   = (state_q == StBusyT1);

  assign h_m_ack     = (state_q == StResp);
  assign h_m_data_in = rsp_q;
  assign bus_error   = err_q;

endmodule

// File: tb/tb_mem_bus_decoder.sv
// Self-checking bench for mem_bus_decoder: vector table plus back-to-back and reset
// sequences; expected responses queue up when requests are driven.
module tb_mem_bus_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] h_m_addr;
  logic [15:0] h_m_data_in;
  logic [15:0] h_m_data_out;
  logic        h_m_access;
  logic        h_m_ack;
  logic        h_m_wr_en;
  logic [1:0]  h_m_bytesel;
  logic [19:1] t0_m_addr, t1_m_addr;
  logic [15:0] t0_m_data_in, t1_m_data_in;
  logic [15:0] t0_m_data_out, t1_m_data_out;
  logic        t0_m_access, t1_m_access;
  logic        t0_m_ack, t1_m_ack;
  logic        t0_m_wr_en, t1_m_wr_en;
  logic [1:0]  t0_m_bytesel, t1_m_bytesel;
  logic        bus_error;

  always #5 clk = ~clk;

  mem_bus_decoder #(
    .WIN_BASE      (19'h7C000),
    .WIN_MASK      (19'h7C000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_m_addr     (h_m_addr),
    .h_m_data_in  (h_m_data_in),
    .h_m_data_out (h_m_data_out),
    .h_m_access   (h_m_access),
    .h_m_ack      (h_m_ack),
    .h_m_wr_en    (h_m_wr_en),
    .h_m_bytesel  (h_m_bytesel),
    .t0_m_addr    (t0_m_addr),
    .t0_m_data_in (t0_m_data_in),
    .t0_m_data_out(t0_m_data_out),
    .t0_m_access  (t0_m_access),
    .t0_m_ack     (t0_m_ack),
    .t0_m_wr_en   (t0_m_wr_en),
    .t0_m_bytesel (t0_m_bytesel),
    .t1_m_addr    (t1_m_addr),
    .t1_m_data_in (t1_m_data_in),
    .t1_m_data_out(t1_m_data_out),
    .t1_m_access  (t1_m_access),
    .t1_m_ack     (t1_m_ack),
    .t1_m_wr_en   (t1_m_wr_en),
    .t1_m_bytesel (t1_m_bytesel),
    .bus_error    (bus_error)
  );

  typedef struct {
    logic [19:1] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [1:0]  bsel;
    logic [15:0] tdata;    // data the target returns
    int          lat;      // access cycle in which the target acks (0 = never)
    logic        spur;     // other target acks in the first busy cycle
    logic        exp_t1;
    int          exp_acc;  // expected number of access cycles
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_ack(input string tag);
    exp_t e;
    if (h_m_ack) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_ack: got ack=1 expected ack=0", tag);
      end else begin
        e = sb.pop_front();
        check({tag, "_rdata"}, 32'(h_m_data_in), 32'(e.data));
        check({tag, "_bus_error"}, 32'(bus_error), 32'(e.err));
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   acc;
    bit   done;
    logic sel_acc, oth_acc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    h_m_access   = 1'b1;
    h_m_addr     = v.addr;
    h_m_data_out = v.wdata;
    h_m_wr_en    = v.wr;
    h_m_bytesel  = v.bsel;
    sb.push_back('{data: v.exp_rd, err: v.exp_err});
    @(negedge clk);
    h_m_access = 1'b0;
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (h_m_ack) begin
        sample_ack(tag);
        check({tag, "_access_cycles"}, 32'(acc), 32'(v.exp_acc));
        check({tag, "_access_low_in_resp"}, {30'd0, t1_m_access, t0_m_access}, 32'd0);
        done = 1'b1;
      end else begin
        sel_acc = v.exp_t1 ? t1_m_access : t0_m_access;
        oth_acc = v.exp_t1 ? t0_m_access : t1_m_access;
        check({tag, "_sel_access"}, 32'(sel_acc), 32'd1);
        check({tag, "_other_access"}, 32'(oth_acc), 32'd0);
        check({tag, "_no_bus_error"}, 32'(bus_error), 32'd0);
        if (sel_acc) begin
          acc++;
          check({tag, "_addr"}, 32'(v.exp_t1 ? t1_m_addr : t0_m_addr), 32'(v.addr));
          check({tag, "_wdata"}, 32'(v.exp_t1 ? t1_m_data_out : t0_m_data_out), 32'(v.wdata));
          check({tag, "_wr_en"}, 32'(v.exp_t1 ? t1_m_wr_en : t0_m_wr_en), 32'(v.wr));
          check({tag, "_bytesel"}, 32'(v.exp_t1 ? t1_m_bytesel : t0_m_bytesel), 32'(v.bsel));
          if (v.spur && acc == 1) begin
            if (v.exp_t1) begin t0_m_ack = 1'b1; t0_m_data_in = 16'hDEAD; end
            else begin t1_m_ack = 1'b1; t1_m_data_in = 16'hDEAD; end
          end
          if (acc == v.lat) begin
            if (v.exp_t1) begin t1_m_ack = 1'b1; t1_m_data_in = v.tdata; end
            else begin t0_m_ack = 1'b1; t0_m_data_in = v.tdata; end
          end
        end
        @(negedge clk);
        t0_m_ack = 1'b0;
        t1_m_ack = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout: got no ack expected ack within 40 cycles", tag);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(h_m_ack), 32'd0);
    check({tag, "_rdata_held"}, 32'(h_m_data_in), 32'(v.exp_rd));
  endtask

  initial begin
    reset        = 1'b1;
    h_m_addr     = '0;
    h_m_data_out = '0;
    h_m_access   = 1'b0;
    h_m_wr_en    = 1'b0;
    h_m_bytesel  = '0;
    t0_m_data_in = '0;
    t1_m_data_in = '0;
    t0_m_ack     = 1'b0;
    t1_m_ack     = 1'b0;

    //             addr       wdata     wr    bsel   tdata     lat spur  t1    acc rd        err
    vecs.push_back('{19'h00100, 16'h0000, 1'b0, 2'b11, 16'hA5A5, 3, 1'b0, 1'b0, 3, 16'hA5A5, 1'b0});
    vecs.push_back('{19'h7C010, 16'h1234, 1'b1, 2'b01, 16'h0BEE, 2, 1'b0, 1'b1, 2, 16'h0BEE, 1'b0});
    vecs.push_back('{19'h7FFFF, 16'h0000, 1'b0, 2'b11, 16'h5A5A, 1, 1'b0, 1'b1, 1, 16'h5A5A, 1'b0});
    vecs.push_back('{19'h7BFFF, 16'h8001, 1'b1, 2'b10, 16'h0001, 1, 1'b0, 1'b0, 1, 16'h0001, 1'b0});
    vecs.push_back('{19'h7C123, 16'h0000, 1'b0, 2'b11, 16'hC0DE, 3, 1'b1, 1'b1, 3, 16'hC0DE, 1'b0});
    vecs.push_back('{19'h00000, 16'h4321, 1'b1, 2'b11, 16'hFFFE, 2, 1'b1, 1'b0, 2, 16'hFFFE, 1'b0});
`ifdef MEM_BUS_DECODER_TIMEOUT_EN
    vecs.push_back('{19'h00400, 16'h0000, 1'b0, 2'b11, 16'h0000, 0, 1'b0, 1'b0, 4, 16'hFFFF, 1'b1});
    vecs.push_back('{19'h7C400, 16'h0000, 1'b0, 2'b11, 16'h6789, 4, 1'b0, 1'b1, 4, 16'h6789, 1'b0});
    vecs.push_back('{19'h7C404, 16'h0000, 1'b0, 2'b11, 16'h0000, 0, 1'b1, 1'b1, 4, 16'hFFFF, 1'b1});
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(h_m_ack), 32'd0);
    check("reset_rdata", 32'(h_m_data_in), 32'd0);
    check("reset_bus_error", 32'(bus_error), 32'd0);
    check("reset_access", {30'd0, t1_m_access, t0_m_access}, 32'd0);
    check("reset_wr_en", {30'd0, t1_m_wr_en, t0_m_wr_en}, 32'd0);
    check("reset_t0_addr", 32'(t0_m_addr), 32'd0);
    check("reset_t1_data", 32'(t1_m_data_out), 32'd0);
    check("reset_bytesel", {28'd0, t1_m_bytesel, t0_m_bytesel}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back: access held through RESP restarts on the first IDLE cycle.
    @(negedge clk);
    h_m_access  = 1'b1;
    h_m_addr    = 19'h00300;
    h_m_wr_en   = 1'b0;
    h_m_bytesel = 2'b11;
    sb.push_back('{data: 16'h1111, err: 1'b0});
    @(negedge clk);
    check("b2b_t0_access", 32'(t0_m_access), 32'd1);
    t0_m_ack     = 1'b1;
    t0_m_data_in = 16'h1111;
    h_m_addr     = 19'h7C300;
    sb.push_back('{data: 16'h2222, err: 1'b0});
    @(negedge clk);
    t0_m_ack = 1'b0;
    check("b2b_ack1", 32'(h_m_ack), 32'd1);
    sample_ack("b2b1");
    @(negedge clk);
    check("b2b_idle_gap_ack", 32'(h_m_ack), 32'd0);
    check("b2b_idle_gap_access", {30'd0, t1_m_access, t0_m_access}, 32'd0);
    @(negedge clk);
    check("b2b_t1_access", {30'd0, t1_m_access, t0_m_access}, 32'd2);
    check("b2b_t1_addr", 32'(t1_m_addr), 32'h7C300);
    t1_m_ack     = 1'b1;
    t1_m_data_in = 16'h2222;
    h_m_access   = 1'b0;
    @(negedge clk);
    t1_m_ack = 1'b0;
    check("b2b_ack2", 32'(h_m_ack), 32'd1);
    sample_ack("b2b2");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample_ack("b2b_extra");
      check("b2b_no_extra_ack", 32'(h_m_ack), 32'd0);
    end

    // Reset during BUSY_T0 drops everything and no ack follows.
    @(negedge clk);
    h_m_access   = 1'b1;
    h_m_addr     = 19'h00200;
    h_m_data_out = 16'h7777;
    h_m_wr_en    = 1'b1;
    @(negedge clk);
    h_m_access = 1'b0;
    check("rst_busy_t0_access", 32'(t0_m_access), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_access", {30'd0, t1_m_access, t0_m_access}, 32'd0);
    check("rst_mid_addr", 32'(t0_m_addr), 32'd0);
    check("rst_mid_wdata", 32'(t0_m_data_out), 32'd0);
    check("rst_mid_wr_en", 32'(t0_m_wr_en), 32'd0);
    check("rst_mid_rdata", 32'(h_m_data_in), 32'd0);
    check("rst_mid_ack", 32'(h_m_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sample_ack("rst_after");
      check("rst_after_no_ack", 32'(h_m_ack), 32'd0);
      check("rst_after_access", 32'(t0_m_access), 32'd0);
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_decoder.md
# mem_bus_decoder

Single-master, two-target memory bus responder that sits on the shared output bus of the instruction/data arbiter. It accepts one 19-bit word-addressed transaction at a time, decodes the address against one configurable window, and forwards the request to target 1 (window hit) or target 0 (everything else). It returns the selected target's data and a one-cycle ack to the master, and optionally aborts a stalled transaction after a timeout.

## Interface
Parameters:
- WIN_BASE, 19'h7C000, word-address base of the target 1 window (bits [19:1])
- WIN_MASK, 19'h7C000, address bits compared against WIN_BASE
- TIMEOUT_CYCLES, 255, busy cycles before abort (used only with timeout compiled in); legal range 1..255, 8-bit counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- h_m_addr  in  19 [19:1]  master word address
- h_m_data_in  out  16  read data to master
- h_m_data_out  in  16  write data from master
- h_m_access  in  1  master request
- h_m_ack  out  1  one-cycle completion strobe
- h_m_wr_en  in  1  1 = write
- h_m_bytesel  in  2  byte lanes
- t0_m_addr / t1_m_addr  out  19  target address
- t0_m_data_in / t1_m_data_in  in  16  target read data
- t0_m_data_out / t1_m_data_out  out  16  target write data
- t0_m_access / t1_m_access  out  1  target request
- t0_m_ack / t1_m_ack  in  1  target completion
- t0_m_wr_en / t1_m_wr_en  out  1  target write enable
- t0_m_bytesel / t1_m_bytesel  out  2  target byte lanes
- bus_error  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, BUSY_T0, BUSY_T1, RESP.
- IDLE: on h_m_access=1, latch addr, data_out, wr_en, bytesel into request register; hit = ((h_m_addr & WIN_MASK) == (WIN_BASE & WIN_MASK)); go BUSY_T1 if hit, else BUSY_T0.
- BUSY_Tn: tn_m_access=1; tn address/data/wr_en/bytesel driven from request register (stable for whole transaction). Other target's access=0. On tn_m_ack: capture tn_m_data_in into response register, go RESP.
- Ack from the non-selected target: ignored.
- RESP: h_m_ack=1 for exactly one cycle; all target access=0; go IDLE.
- h_m_data_in: driven from response register at all times; holds last value until the next capture (writes capture target data_in as well).
- h_m_access dropped during BUSY (protocol violation): transaction still completes; h_m_ack still pulses.
- IDLE does not sample h_m_access in the RESP cycle; a request held high across RESP starts a new transaction on the first IDLE cycle.
- Unselected target outputs: addr/data/wr_en/bytesel still driven from request register; access=0.

## Timing
- Reset values: state IDLE; h_m_ack=0, h_m_data_in=0, bus_error=0, all tn_m_access=0, tn_m_wr_en=0, addr/data/bytesel=0.
- Request sampled at edge N → tn_m_access high from cycle N+1.
- Target ack sampled at edge M → h_m_ack high in cycle M+1 only; tn_m_access low from M+1.
- Minimum turnaround (target acks in its first access cycle): h_m_ack in cycle N+2; next request accepted at edge N+3.
- Reset mid-transaction: immediate return to reset values; no ack issued.

## Configuration
- MEM_BUS_DECODER_TIMEOUT_EN defined: 8-bit counter cleared on IDLE→BUSY, increments each BUSY cycle without target ack; when count reaches TIMEOUT_CYCLES, target access dropped, response register loaded with 16'hFFFF, go RESP, bus_error pulses in the same cycle as h_m_ack. Target ack in the expiry cycle wins (normal response, no bus_error).
- Not defined: no counter; BUSY waits indefinitely; bus_error tied 0.

## Structure
- Shared package mem_bus_pkg: state enum typedef, request struct (addr[19:1], data[15:0], wr_en, bytesel[1:0]), default window constants.
- One sub-module: mem_bus_timeout (counter, clear/enable inputs, expired output), instantiated only under MEM_BUS_DECODER_TIMEOUT_EN.

## Test plan
- Read 19'h00100, t0 acks 3 cycles after access with 16'hA5A5 → t0 access 3 cycles, t1 never; h_m_ack one cycle, h_m_data_in=16'hA5A5 held afterward.
- Write 19'h7C010, data 16'h1234, bytesel 2'b01 → t1 sees exact values stable until ack; t0 access stays 0.
- Back-to-back: master re-asserts access in RESP cycle → second transaction starts next IDLE cycle, exactly one ack per transaction.
- Spurious t0_m_ack during BUSY_T1 → ignored; completes only on t1_m_ack.
- Timeout (macro on, TIMEOUT_CYCLES=4, target never acks) → abort after 4 busy cycles; h_m_ack and bus_error together; h_m_data_in=16'hFFFF; ack arriving on cycle 4 → normal data, no bus_error.
- Reset asserted during BUSY_T0 → all outputs to reset values immediately; no h_m_ack after release.
